// File: rtl/perf_monitor_pkg.sv
// perf_monitor_pkg: run-state encoding and snapshot read-select codes for the pipeline performance monitor.
package perf_monitor_pkg;
  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_e;
  localparam logic [1:0] SEL_CYCLE  = 2'd0;
  localparam logic [1:0] SEL_STALL  = 2'd1;
  localparam logic [1:0] SEL_FLUSH  = 2'd2;
  localparam logic [1:0] SEL_RETIRE = 2'd3;
  localparam int NUM_CNT = 4;
endpackage

// File: rtl/perf_monitor_sat_counter.sv
// sat_counter: enable-driven event counter with synchronous clear that sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] nxt_o
);
  logic [WIDTH-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : (en_i && !(&cnt_q)) ? cnt_q + WIDTH'(1) : cnt_q;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  // The next-state value lets the parent snapshot and limit-check the post-increment count.
  assign nxt_o = cnt_d;
endmodule

// File: rtl/perf_monitor.sv
// perf_monitor: counts cycles, stalls, flushes and retirements while running, with atomic snapshots and auto-halt.
module perf_monitor
  import perf_monitor_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int CYCLE_LIMIT = 30
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             branch_i,
  input  logic             flush_i,
  input  logic             retire_i,
  input  logic             clear_i,
  input  logic             snap_i,
  input  logic             rd_en_i,
  input  logic [1:0]       rd_sel_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_valid_o,
  output logic             halt_o,
  output logic             done_o
);
  state_e state_q, state_d;
  logic [NUM_CNT-1:0] en;
  logic [WIDTH-1:0] nxt [NUM_CNT];
  logic [WIDTH-1:0] shadow_q [NUM_CNT];
  logic [WIDTH-1:0] shadow_d [NUM_CNT];
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic rd_valid_q, done_q, done_d, running, hit;
  assign running = state_q == RUN;
  assign en = {running & retire_i, running & flush_i, running & stall_i & ~branch_i, running};
  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    sat_counter #(.WIDTH(WIDTH)) u_cnt (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .en_i (en[g]),
      .clr_i(clear_i),
      .nxt_o(nxt[g])
    );
  end
  // Widened compare so a limit larger than the counter range never aliases.
  assign hit = (CYCLE_LIMIT != 0) && ({32'b0, nxt[SEL_CYCLE]} == (WIDTH + 32)'(CYCLE_LIMIT));
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    if (clear_i) state_d = IDLE;
    else if (state_q == IDLE && start_i) state_d = RUN;
    else if (running && hit) begin
      state_d = HALTED;
      done_d  = 1'b1;
    end
    else if (running && !start_i) state_d = IDLE;
  end
  always_comb begin
    for (int i = 0; i < NUM_CNT; i++) shadow_d[i] = clear_i ? '0 : snap_i ? nxt[i] : shadow_q[i];
    rd_data_d = rd_en_i ? shadow_d[rd_sel_i] : rd_data_q;
  end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      state_q    <= IDLE;
      shadow_q   <= '{default: '0};
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en_i;
      done_q     <= done_d;
    end
  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign halt_o     = state_q == HALTED;
  assign done_o     = done_q;
endmodule

// File: tb/tb_perf_monitor.sv
// tb_perf_monitor: two monitors (32-bit and 4-bit counters) share random stimulus and are scored against a reference model.
module tb_perf_monitor;
  localparam int LIMIT = 30;
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;
  logic clk_i = 0, rst_i = 0, start_i = 0, stall_i = 0, branch_i = 0, flush_i = 0;
  logic retire_i = 0, clear_i = 0, snap_i = 0, rd_en_i = 0;
  logic [1:0] rd_sel_i = 0;
  logic [31:0] rd_data_a;
  logic [3:0] rd_data_b;
  logic rd_valid_a, rd_valid_b, halt_a, halt_b, done_a, done_b;
  int total = 0, bad = 0, done_seen = 0;
  longint unsigned cnt [2][4];
  longint unsigned sh [2][4];
  longint unsigned maxv [2] = '{64'hFFFF_FFFF, 64'd15};
  longint unsigned last [2];
  longint unsigned qa [$];
  longint unsigned qb [$];
  int st [2];
  bit exp_done [2];
  always #5 clk_i = ~clk_i;
  perf_monitor dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i), .branch_i(branch_i),
    .flush_i(flush_i), .retire_i(retire_i), .clear_i(clear_i), .snap_i(snap_i), .rd_en_i(rd_en_i),
    .rd_sel_i(rd_sel_i), .rd_data_o(rd_data_a), .rd_valid_o(rd_valid_a), .halt_o(halt_a), .done_o(done_a)
  );
  perf_monitor #(.WIDTH(4), .CYCLE_LIMIT(LIMIT)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i), .branch_i(branch_i),
    .flush_i(flush_i), .retire_i(retire_i), .clear_i(clear_i), .snap_i(snap_i), .rd_en_i(rd_en_i),
    .rd_sel_i(rd_sel_i), .rd_data_o(rd_data_b), .rd_valid_o(rd_valid_b), .halt_o(halt_b), .done_o(done_b)
  );
  task automatic check(string name, longint unsigned act, longint unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic longint unsigned bump(longint unsigned v, int k);
    return v >= maxv[k] ? v : v + 1;
  endfunction
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      st[k] = M_IDLE;
      exp_done[k] = 0;
      last[k] = 0;
      for (int j = 0; j < 4; j++) begin
        cnt[k][j] = 0;
        sh[k][j] = 0;
      end
    end
    qa.delete();
    qb.delete();
  endtask
  // One rising edge of the behavioural model, using the inputs currently applied.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      exp_done[k] = 0;
      if (clear_i) begin
        st[k] = M_IDLE;
        for (int j = 0; j < 4; j++) begin
          cnt[k][j] = 0;
          sh[k][j] = 0;
        end
      end else begin
        if (st[k] == M_RUN) begin
          cnt[k][0] = bump(cnt[k][0], k);
          if (stall_i && !branch_i) cnt[k][1] = bump(cnt[k][1], k);
          if (flush_i) cnt[k][2] = bump(cnt[k][2], k);
          if (retire_i) cnt[k][3] = bump(cnt[k][3], k);
          if (cnt[k][0] == LIMIT) begin
            st[k] = M_HALT;
            exp_done[k] = 1;
          end else if (!start_i) st[k] = M_IDLE;
        end else if (st[k] == M_IDLE && start_i) st[k] = M_RUN;
        if (snap_i) for (int j = 0; j < 4; j++) sh[k][j] = cnt[k][j];
      end
      if (rd_en_i) begin
        if (k == 0) qa.push_back(sh[k][rd_sel_i]);
        else qb.push_back(sh[k][rd_sel_i]);
      end
    end
  endtask
  task automatic mon_read(int k, logic v, longint unsigned d);
    longint unsigned e;
    int n;
    n = (k == 0) ? qa.size() : qb.size();
    if (v && n == 0) begin
      total++;
      bad++;
      $display("FAIL rd_valid_%0d: got unexpected valid with data %0d, expected no response", k, d);
    end else if (n != 0) begin
      if (k == 0) e = qa.pop_front();
      else e = qb.pop_front();
      check($sformatf("rd_valid_%0d", k), 64'(v), 1);
      check($sformatf("rd_data_%0d", k), d, e);
      last[k] = e;
    end else check($sformatf("rd_hold_%0d", k), d, last[k]);
  endtask
  always @(negedge clk_i) if (rst_i) begin
    check("halt_a", 64'(halt_a), 64'(st[0] == M_HALT));
    check("halt_b", 64'(halt_b), 64'(st[1] == M_HALT));
    check("done_a", 64'(done_a), 64'(exp_done[0]));
    check("done_b", 64'(done_b), 64'(exp_done[1]));
    if (done_a) done_seen++;
    mon_read(0, rd_valid_a, 64'(rd_data_a));
    mon_read(1, rd_valid_b, 64'(rd_data_b));
  end
  task automatic tick();
    @(posedge clk_i);
    model_edge();
    #1;
    snap_i = 0;
    clear_i = 0;
    rd_en_i = 0;
  endtask
  task automatic read_all();
    for (int s = 0; s < 4; s++) begin
      rd_en_i = 1;
      rd_sel_i = 2'(s);
      tick();
    end
    tick();
  endtask
  task automatic check_zero_outputs(string tag);
    check({tag, "_rd_data_a"}, 64'(rd_data_a), 0);
    check({tag, "_rd_valid_a"}, 64'(rd_valid_a), 0);
    check({tag, "_halt_a"}, 64'(halt_a), 0);
    check({tag, "_done_a"}, 64'(done_a), 0);
    check({tag, "_rd_data_b"}, 64'(rd_data_b), 0);
    check({tag, "_rd_valid_b"}, 64'(rd_valid_b), 0);
    check({tag, "_halt_b"}, 64'(halt_b), 0);
    check({tag, "_done_b"}, 64'(done_b), 0);
  endtask
  initial begin
    model_reset();
    #1;
    check_zero_outputs("reset");
    @(posedge clk_i);
    #1 rst_i = 1;
    start_i = 1;
    repeat (10) tick();
    start_i = 0;
    snap_i = 1;
    tick();
    read_all();
    clear_i = 1;
    tick();
    start_i = 1;
    tick();
    stall_i = 1;
    tick();
    branch_i = 1;
    tick();
    branch_i = 0;
    tick();
    stall_i = 0;
    snap_i = 1;
    tick();
    start_i = 0;
    read_all();
    clear_i = 1;
    tick();
    done_seen = 0;
    start_i = 1;
    repeat (40) begin
      {stall_i, branch_i, flush_i, retire_i} = 4'($urandom);
      tick();
    end
    snap_i = 1;
    tick();
    read_all();
    check("done_pulse_count", 64'(done_seen), 1);
    {stall_i, branch_i, flush_i, retire_i} = 4'b0;
    clear_i = 1;
    tick();
    retire_i = 1;
    repeat (20) tick();
    snap_i = 1;
    tick();
    retire_i = 0;
    start_i = 0;
    read_all();
    start_i = 1;
    repeat (5) tick();
    clear_i = 1;
    snap_i = 1;
    tick();
    start_i = 0;
    read_all();
    repeat (400) begin
      start_i = $urandom_range(0, 9) != 0;
      {stall_i, branch_i, flush_i, retire_i} = 4'($urandom);
      clear_i = $urandom_range(0, 99) == 0;
      snap_i = $urandom_range(0, 7) == 0;
      rd_en_i = $urandom_range(0, 2) == 0;
      rd_sel_i = 2'($urandom);
      tick();
    end
    {stall_i, branch_i, flush_i, retire_i} = 4'b0;
    clear_i = 1;
    tick();
    start_i = 1;
    repeat (5) tick();
    snap_i = 1;
    rd_en_i = 1;
    rd_sel_i = 0;
    tick();
    #1 rst_i = 0;
    #1;
    check_zero_outputs("async_reset");
    model_reset();
    #10 rst_i = 1;
    repeat (6) tick();
    snap_i = 1;
    tick();
    start_i = 0;
    read_all();
    check("queue_a_empty", 64'(qa.size()), 0);
    check("queue_b_empty", 64'(qb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/perf_monitor.md
PERF_MONITOR -- requirements
Module: perf_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the width of every event counter.
REQ-002 SHALL have parameter CYCLE_LIMIT, default 30, the run length in cycles before auto-halt; 0 disables auto-halt.
REQ-003 SHALL have port clk_i  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_i  input  1  the reset, asynchronous and active-low.
REQ-005 SHALL have port start_i  input  1  level; CPU running enable.
REQ-006 SHALL have port stall_i  input  1  hazard-unit stall request.
REQ-007 SHALL have port branch_i  input  1  control-unit Branch for the ID-stage instruction.
REQ-008 SHALL have port flush_i  input  1  hazard-unit IF/ID flush.
REQ-009 SHALL have port retire_i  input  1  MEM/WB stage holds a valid instruction this cycle.
REQ-010 SHALL have port clear_i  input  1  synchronous clear of all counters and snapshots.
REQ-011 SHALL have port snap_i  input  1  one-cycle pulse; atomic snapshot of all counters.
REQ-012 SHALL have port rd_en_i  input  1  read request.
REQ-013 SHALL have port rd_sel_i  input  2  snapshot select: 0 cycle, 1 stall, 2 flush, 3 retire.
REQ-014 SHALL have port rd_data_o  output  WIDTH  selected snapshot value.
REQ-015 SHALL have port rd_valid_o  output  1  rd_data_o is valid.
REQ-016 SHALL have port halt_o  output  1  level; cycle limit reached.
REQ-017 SHALL have port done_o  output  1  one-cycle pulse on entry to HALTED.

Function
REQ-018 SHALL implement FSM IDLE -> RUN when start_i=1; RUN -> IDLE when start_i=0; RUN -> HALTED on the edge where the post-increment cycle count equals CYCLE_LIMIT (CYCLE_LIMIT != 0); HALTED -> IDLE only on clear_i.
REQ-019 SHALL, in RUN only, increment cycle each cycle; stall when stall_i=1 and branch_i=0; flush when flush_i=1; retire when retire_i=1.
REQ-020 SHALL hold all counters in IDLE and HALTED.
REQ-021 SHALL saturate every counter at 2^WIDTH-1 with no wrap-around.
REQ-022 SHALL assert halt_o in HALTED; done_o SHALL pulse exactly one cycle on the RUN->HALTED edge.
REQ-023 SHALL copy all four counters into shadow registers on snap_i in the same edge. The copied values SHALL include any increment occurring on that edge.
REQ-024 SHALL return rd_data_o = shadow[rd_sel_i] with rd_valid_o=1 exactly one cycle after rd_en_i; otherwise rd_valid_o=0 and rd_data_o holds its last value.
REQ-025 SHALL give clear_i priority over snap_i, and snap_i priority over counting. Clear SHALL zero counters and shadows and move the FSM to IDLE.
REQ-026 SHALL, when rd_en_i coincides with snap_i, return the newly captured value.
REQ-027 SHALL let start_i deassertion mid-run freeze the counts; reassertion SHALL resume counting without clearing.

Reset
REQ-028 SHALL, on rst_i=0, immediately and asynchronously put the FSM in IDLE and zero all counters and shadows, with rd_data_o=0, rd_valid_o=0, halt_o=0, done_o=0.
REQ-029 SHALL, when reset is asserted mid-RUN or mid-read, drop any pending rd_valid_o and not emit done_o.

Structure
REQ-030 SHALL place the FSM state encoding and the rd_sel_i codes (SEL_CYCLE, SEL_STALL, SEL_FLUSH, SEL_RETIRE) in the shared CPU package.
REQ-031 SHALL instantiate one sub-module, sat_counter (WIDTH, enable, clear, saturate), four times.

Verification
REQ-032 SHALL cover: reset, then start_i=1 for 10 cycles with no events, snap, read sel 0 -> rd_data_o=10 one cycle later, rd_valid_o=1 for one cycle.
REQ-033 SHALL cover: stall_i=1 for 3 cycles, with branch_i=1 on one of them -> stall count 2.
REQ-034 SHALL cover: CYCLE_LIMIT=30, start held -> done_o pulses once with cycle=30, halt_o stays 1, and further events leave counts unchanged.
REQ-035 SHALL cover: WIDTH=4, retire_i held 20 cycles -> retire reads 15.
REQ-036 SHALL cover: clear_i and snap_i in the same cycle -> all reads 0, FSM IDLE; rst_i low mid-run -> all outputs 0 without waiting for a clock edge.
